// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle controller/datapath. Accepts
//   single-word or 8-beat burst read/write requests, services them from an
//   internal word-addressed RAM after WAIT_CYC wait states per beat, and
//   returns a one-cycle acknowledge per beat plus read data for read beats.
//
// Parameters
//   ADDR_W      request (word) address width
//   DATA_W      data word width
//   DEPTH_LOG2  RAM holds 2^DEPTH_LOG2 words, index = addr[DEPTH_LOG2-1:0]
//   WAIT_CYC    wait states before every beat, legal range 0..15
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   req_valid   request present
//   req_ready   high exactly when idle (request can be accepted)
//   req_we      1 = write, 0 = read (sampled at acceptance)
//   req_burst   1 = 8 beats, 0 = 1 beat (sampled at acceptance)
//   req_addr    start word address (sampled at acceptance)
//   req_wdata   write data of the current beat (sampled at the ACCESS edge)
//   beat_ack    one-cycle pulse after each completed beat
//   rsp_valid   one-cycle pulse with rsp_rdata, read beats only
//   rsp_rdata   read data, holds its last value between pulses
//   rsp_last    high together with beat_ack on the final beat
//   beat_idx    index (0..7) of the beat in progress
//   busy        high whenever a request is being serviced
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on the responder's own
// state, never on req_valid. A request presented while req_ready is low is
// not accepted and leaves no trace; the initiator must hold it until ready.
//
// The FSM state is available on the internal signal `state` (state_t) for
// debug and checker binding; req_ready/busy are direct decodes of it.

module mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              beat_ack,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic [2:0]        beat_idx,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);
  localparam bit         NO_WAIT   = (WAIT_CYC == 0);

  state_t                state;
  state_t                state_nxt;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            beats_left;
  logic [3:0]            wait_cnt;
  logic                  accept;
  logic                  last_beat;
  logic                  do_write;
  logic [DEPTH_LOG2-1:0] mem_idx;

  // Not reset: contents survive rst.
  logic [DATA_W-1:0]     mem [1<<DEPTH_LOG2];

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign last_beat = (beats_left == 3'd0);
  assign mem_idx   = addr_q[DEPTH_LOG2-1:0];
  assign do_write  = (state == ST_ACCESS) & we_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = NO_WAIT ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // wait_cnt was loaded with WAIT_CYC, so this leaves after WAIT_CYC cycles.
        if (wait_cnt == 4'd1) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (last_beat) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = NO_WAIT ? ST_ACCESS : ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request context, beat sequencing and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      beats_left <= '0;
      wait_cnt   <= '0;
      beat_idx   <= '0;
      beat_ack   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      beat_ack  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            addr_q     <= req_addr;
            beats_left <= req_burst ? 3'd7 : 3'd0;
            beat_idx   <= 3'd0;
            wait_cnt   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        ST_ACCESS: begin
          beat_ack <= 1'b1;
          rsp_last <= last_beat;
          if (!we_q) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem[mem_idx];
          end
          if (!last_beat) begin
            // Address wraps at 2^ADDR_W; the RAM index wraps at 2^DEPTH_LOG2.
            addr_q     <= addr_q + ADDR_W'(1);
            beats_left <= beats_left - 3'd1;
            beat_idx   <= beat_idx + 3'd1;
            wait_cnt   <= WAIT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Write port. The !rst term drops a beat whose ACCESS edge coincides with
  // reset, so an interrupted beat never lands in the array.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      mem[mem_idx] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Bench for mem_responder. Two instances share the request inputs: u_dut_w1
//   (WAIT_CYC = 1) and u_dut_w0 (WAIT_CYC = 0); `sel` steers req_valid to one
//   of them and selects which one's outputs the driver observes.
//   Expected values come from a word-array model of each RAM and from the
//   beat timing rule: beat i of a request presented in cycle 0 is
//   acknowledged in cycle (i+1)*(W+1)+1.

module tb_mem_responder;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT wiring
  logic        sel;            // 0 = u_dut_w1, 1 = u_dut_w0
  logic        req_valid, req_we, req_burst;
  logic [15:0] req_addr, req_wdata;
  logic        v1, v0;

  logic        r1_ready, r1_ack, r1_valid, r1_last, r1_busy;
  logic [15:0] r1_rdata;
  logic [2:0]  r1_idx;
  logic        r0_ready, r0_ack, r0_valid, r0_last, r0_busy;
  logic [15:0] r0_rdata;
  logic [2:0]  r0_idx;

  logic        m_ready, m_ack, m_valid, m_last, m_busy;
  logic [15:0] m_rdata;
  logic [2:0]  m_idx;

  assign v1 = req_valid & ~sel;
  assign v0 = req_valid & sel;

  assign m_ready = sel ? r0_ready : r1_ready;
  assign m_ack   = sel ? r0_ack   : r1_ack;
  assign m_valid = sel ? r0_valid : r1_valid;
  assign m_last  = sel ? r0_last  : r1_last;
  assign m_busy  = sel ? r0_busy  : r1_busy;
  assign m_rdata = sel ? r0_rdata : r1_rdata;
  assign m_idx   = sel ? r0_idx   : r1_idx;

  mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYC(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1_ready), .req_we(req_we),
    .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
    .beat_ack(r1_ack), .rsp_valid(r1_valid), .rsp_rdata(r1_rdata),
    .rsp_last(r1_last), .beat_idx(r1_idx), .busy(r1_busy)
  );

  mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYC(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(r0_ready), .req_we(req_we),
    .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
    .beat_ack(r0_ack), .rsp_valid(r0_valid), .rsp_rdata(r0_rdata),
    .rsp_last(r0_last), .beat_idx(r0_idx), .busy(r0_busy)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_checks;
  int          n_fail;
  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [2][256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ridx(input logic [15:0] a, input int i);
    logic [15:0] t;
    t = a + 16'(i);
    return t[7:0];
  endfunction

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_ready_w1"}, 32'(r1_ready), 32'd1);
    chk({tag, "_busy_w1"},  32'(r1_busy),  32'd0);
    chk({tag, "_ack_w1"},   32'(r1_ack),   32'd0);
    chk({tag, "_valid_w1"}, 32'(r1_valid), 32'd0);
    chk({tag, "_last_w1"},  32'(r1_last),  32'd0);
    chk({tag, "_idx_w1"},   32'(r1_idx),   32'd0);
    chk({tag, "_rdata_w1"}, 32'(r1_rdata), 32'd0);
    chk({tag, "_ready_w0"}, 32'(r0_ready), 32'd1);
    chk({tag, "_busy_w0"},  32'(r0_busy),  32'd0);
    chk({tag, "_ack_w0"},   32'(r0_ack),   32'd0);
    chk({tag, "_valid_w0"}, 32'(r0_valid), 32'd0);
    chk({tag, "_last_w0"},  32'(r0_last),  32'd0);
    chk({tag, "_idx_w0"},   32'(r0_idx),   32'd0);
    chk({tag, "_rdata_w0"}, 32'(r0_rdata), 32'd0);
  endtask

  // ---------------------------------------------------------------- driver
  // Presents one request on the selected instance (call at a falling edge
  // while it is idle) and follows it beat by beat. Beat i carries
  // base + i*step. abort_rel > 0 asserts rst at that relative cycle;
  // poke_rel > 0 pulses a stray write request to 0x0020 while busy.
  task automatic do_txn(input bit s, input bit we, input bit burst,
                        input logic [15:0] addr, input logic [15:0] base,
                        input logic [15:0] step, input int abort_rel,
                        input int poke_rel, output int last_rel,
                        output logic [15:0] first_rd);
    int          n, w, beat, rel, exp_rel;
    bit          done;
    logic [2:0]  prev_idx;
    logic [15:0] exp_d;
    n = burst ? 8 : 1;
    w = s ? 0 : 1;
    last_rel = -1;
    first_rd = '0;
    sel = s;
    #1;
    chk("ready_at_issue", 32'(m_ready), 32'd1);
    if (!we) begin
      for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[s][ridx(addr, i)]);
    end
    req_valid = 1'b1; req_we = we; req_burst = burst; req_addr = addr; req_wdata = base;
    beat = 0; rel = 0; done = 1'b0;
    while (!done) begin
      prev_idx = m_idx;
      @(negedge clk);
      rel++;
      if (rel == 1) req_valid = 1'b0;
      exp_rel = (beat + 1) * (w + 1) + 1;
      if (m_ack) begin
        chk("ack_cycle", 32'(rel), 32'(exp_rel));
        chk("rsp_valid_on_read", 32'(m_valid), 32'(!we));
        chk("rsp_last", 32'(m_last), 32'(beat == n - 1));
        chk("beat_idx", 32'(prev_idx), 32'(beat));
        chk("busy_at_ack", 32'(m_busy), 32'(beat != n - 1));
        if (!we) begin
          if (m_valid && exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            chk("rdata", 32'(m_rdata), 32'(exp_d));
          end
          if (beat == 0) first_rd = m_rdata;
        end else begin
          ref_mem[s][ridx(addr, beat)] = base + 16'(beat) * step;
          req_wdata = base + 16'(beat + 1) * step;
        end
        beat++;
        if (beat == n) begin
          last_rel = rel;
          done = 1'b1;
        end
      end else begin
        chk("no_rsp_between_beats", 32'(m_valid), 32'd0);
        if (rel > exp_rel) begin
          chk("ack_in_time", 32'(rel), 32'(exp_rel));
          done = 1'b1;
        end
      end
      if (rel == poke_rel) begin
        req_valid = 1'b1; req_we = 1'b1; req_burst = 1'b0;
        req_addr = 16'h0020; req_wdata = 16'hBEEF;
      end
      if (rel == poke_rel + 1) begin
        req_valid = 1'b0; req_we = we; req_burst = burst; req_addr = addr;
      end
      if (rel == abort_rel) begin
        rst = 1'b1;
        exp_q.delete();
        done = 1'b1;
      end
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit          s;
    bit          we;
    bit          burst;
    logic [15:0] addr;
    logic [15:0] base;
    logic [15:0] step;
    int          exp_last;
    logic [15:0] exp_rd;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  // ---------------------------------------------------------------- test body
  initial begin
    int          lr;
    logic [15:0] fr;
    bit          rs, rwe, rb;
    logic [15:0] raddr, rbase, rstep;
    int          gap;

    n_checks = 0;
    n_fail   = 0;
    sel      = 1'b0;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, 3,  16'h0000};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 3,  16'h1234};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h00FE, 16'h00A0, 16'h0001, 17, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h00FE, 16'h0000, 16'h0000, 17, 16'h00A0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3,  16'h00A2};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 17, 16'h00A0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h7777, 16'h0000, 2,  16'h0000};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 2,  16'h7777};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 16'h00FC, 16'h1000, 16'h0101, 9,  16'h0000};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 16'h00FC, 16'h0000, 16'h0000, 9,  16'h1000};

    // Power-on reset with a write request pending.
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_burst = 1'b0;
    req_addr = 16'h0010; req_wdata = 16'hDEAD;
    repeat (3) @(negedge clk);
    #1 chk_rst_vals("por");
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("por_ready_after_w1", 32'(r1_ready), 32'd1);
    chk("por_ready_after_w0", 32'(r0_ready), 32'd1);

    // Fill both RAMs so every model word is known.
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 32; b++) begin
        do_txn(s == 1, 1'b1, 1'b1, 16'(b * 8), 16'($urandom), 16'($urandom), 0, 0, lr, fr);
      end
    end

    // Directed vectors.
    for (int k = 0; k < NV; k++) begin
      do_txn(tbl[k].s, tbl[k].we, tbl[k].burst, tbl[k].addr, tbl[k].base,
             tbl[k].step, 0, 0, lr, fr);
      chk($sformatf("vec%0d_last_cycle", k), 32'(lr), 32'(tbl[k].exp_last));
      if (!tbl[k].we) chk($sformatf("vec%0d_rdata0", k), 32'(fr), 32'(tbl[k].exp_rd));
    end

    // Reset while idle with a write request present: nothing is written.
    @(negedge clk);
    sel = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_burst = 1'b0;
    req_addr = 16'h0010; req_wdata = 16'hDEAD;
    rst = 1'b1;
    #1 chk_rst_vals("idle_rst_assert");
    repeat (3) @(negedge clk);
    #1 chk_rst_vals("idle_rst_hold");
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0, 0, 0, lr, fr);
    chk("idle_rst_no_write", 32'(fr), 32'h1234);

    // WAIT_CYC = 0 back-to-back single reads, second in the first's response cycle.
    sel = 1'b1;
    #1;
    chk("b2b_ready0", 32'(m_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_burst = 1'b0; req_addr = 16'h0011;
    @(negedge clk);
    chk("b2b_c1_ready", 32'(m_ready), 32'd0);
    chk("b2b_c1_busy", 32'(m_busy), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c2_ack", 32'(m_ack), 32'd1);
    chk("b2b_c2_valid", 32'(m_valid), 32'd1);
    chk("b2b_c2_last", 32'(m_last), 32'd1);
    chk("b2b_c2_rdata", 32'(m_rdata), 32'(ref_mem[1][8'h11]));
    chk("b2b_c2_ready", 32'(m_ready), 32'd1);
    req_valid = 1'b1; req_addr = 16'h0033;
    @(negedge clk);
    chk("b2b_c3_ready", 32'(m_ready), 32'd0);
    chk("b2b_c3_valid", 32'(m_valid), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c4_valid", 32'(m_valid), 32'd1);
    chk("b2b_c4_rdata", 32'(m_rdata), 32'(ref_mem[1][8'h33]));

    // Reset during the WAIT of beat 3 of a write burst over zeroed words.
    do_txn(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'h0000, 0, 0, lr, fr);
    do_txn(1'b0, 1'b1, 1'b1, 16'h0040, 16'h00B0, 16'h0001, 7, 0, lr, fr);
    #1 chk_rst_vals("burst_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0, 16'h0, 0, 0, lr, fr);
    chk("burst_rst_beat0", 32'(fr), 32'h00B0);
    do_txn(1'b0, 1'b0, 1'b0, 16'h0042, 16'h0, 16'h0, 0, 0, lr, fr);
    chk("burst_rst_beat2", 32'(fr), 32'h00B2);
    do_txn(1'b0, 1'b0, 1'b0, 16'h0043, 16'h0, 16'h0, 0, 0, lr, fr);
    chk("burst_rst_beat3", 32'(fr), 32'h0000);

    // Stray write request while a read burst is busy.
    do_txn(1'b0, 1'b0, 1'b1, 16'h0018, 16'h0, 16'h0, 0, 5, lr, fr);
    chk("busy_ignore_last", 32'(lr), 32'd17);
    do_txn(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h0, 0, 0, lr, fr);

    // Randomized traffic against the model.
    repeat (40) begin
      rs  = 1'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       raddr = 16'hFFF8 | 16'($urandom_range(0, 7));
        1:       raddr = 16'h00F8 | 16'($urandom_range(0, 7));
        default: raddr = 16'($urandom);
      endcase
      rbase = 16'($urandom);
      rstep = 16'($urandom_range(0, 3));
      do_txn(rs, rwe, rb, raddr, rbase, rstep, 0, 0, lr, fr);
      chk("rand_last_cycle", 32'(lr), 32'((rb ? 8 : 1) * ((rs ? 0 : 1) + 1) + 1));
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle controller/datapath. It accepts single-word or 8-beat burst read/write requests from the initiator side: instruction fetch, LW/SW, and LM/SM sequences. It services them from an internal word-addressed RAM with a programmable number of wait states, and returns per-beat acknowledges and read data. It sits between the datapath's memory address/data muxes and the storage array.

## Interface
Parameters:
- ADDR_W, 16, request address width (word address)
- DATA_W, 16, data word width
- DEPTH_LOG2, 8, RAM holds 2^DEPTH_LOG2 words; index = addr[DEPTH_LOG2-1:0]
- WAIT_CYC, 1, wait states inserted before every beat; legal range 0..15

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request; high exactly when state = IDLE
- req_we  in  1  1 = write, 0 = read; sampled at acceptance
- req_burst  in  1  1 = 8 beats, 0 = 1 beat; sampled at acceptance
- req_addr  in  ADDR_W  start word address; sampled at acceptance
- req_wdata  in  DATA_W  write data for the current beat; sampled at the edge ending ACCESS
- beat_ack  out  1  one-cycle pulse after each completed beat, read or write
- rsp_valid  out  1  one-cycle pulse with rsp_rdata, read beats only
- rsp_rdata  out  DATA_W  read data; holds its last value between pulses
- rsp_last  out  1  high together with beat_ack on the final beat
- beat_idx  out  3  index of the beat in progress, 0..7
- busy  out  1  high when state ≠ IDLE

## Operation
- Accept: req_valid & req_ready at a rising edge. On acceptance, latch we, burst and addr, set beats_left = burst ? 7 : 0, set beat_idx = 0 and load wait_cnt = WAIT_CYC.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE → WAIT on accept when WAIT_CYC > 0; IDLE → ACCESS on accept when WAIT_CYC = 0.
  - WAIT: decrement wait_cnt every cycle; go to ACCESS when wait_cnt = 1.
  - ACCESS lasts 1 cycle. At its ending edge:
    - write: mem[index] <= req_wdata.
    - read: rsp_rdata <= mem[index] and rsp_valid <= 1.
    - always: beat_ack <= 1 and rsp_last <= (beats_left == 0).
  - ACCESS next state:
    - beats_left > 0: addr <= addr + 1 (mod 2^ADDR_W), beats_left--, beat_idx++, reload wait_cnt, then go to WAIT, or stay in ACCESS when WAIT_CYC = 0.
    - beats_left = 0: go to IDLE.
- Requests presented while busy are ignored (req_ready = 0) and have no side effects.
- Burst write data: the initiator changes req_wdata to the next beat's value in the cycle beat_ack is high. With WAIT_CYC = 0, that same cycle is the next ACCESS.
- Address wrap: the address wraps 0xFFFF → 0x0000. The RAM index wraps modulo 2^DEPTH_LOG2, so bursts can cross the array end.
- RAM contents are not cleared by rst.

## Timing
- Reset values (asynchronous, immediate): state = IDLE, req_ready = 1, busy = 0, beat_ack = 0, rsp_valid = 0, rsp_last = 0, beat_idx = 0, rsp_rdata = 0.
- Single-beat latency: request accepted at the end of cycle 0 → WAIT in cycles 1..W → ACCESS in cycle W+1 → beat_ack/rsp_valid in cycle W+2. For W = 0 the response is in cycle 2.
- Burst: beats are spaced W+1 cycles apart. An 8-beat burst completes with rsp_last in cycle 8(W+1)+1.
- The response cycle of the last beat is an IDLE cycle (req_ready = 1), so a back-to-back request can be accepted with no bubble.
- Reset mid-operation:
  - The FSM returns to IDLE and all pulses clear.
  - Beats whose ACCESS edge already occurred stay written.
  - The beat in progress and later beats are not performed.
  - There is no partial response after reset.
- busy falls in the same cycle that the final beat_ack rises.

## Test plan
- Reset: assert rst for 3 cycles mid-idle with req_valid = 1 → all outputs at reset values, no access performed; req_ready = 1 during and after reset.
- Single write then read, W = 1: write 0x1234 to 0x0010, then read 0x0010 → write beat_ack in cycle 3; read rsp_valid in cycle 3 after its accept with rsp_rdata = 0x1234 and rsp_last = 1.
- Wrapping burst, DEPTH_LOG2 = 8: burst write 0xA0..0xA7 from 0x00FE, then burst read from 0x00FE.
  - Expect 8 rsp_valid pulses with data 0xA0..0xA7 and beat_idx 0..7.
  - rsp_last is high only on beat 7.
  - mem[0x00] = 0xA2.
- W = 0 back-to-back: two single reads, the second presented in the response cycle of the first → second accepted with no bubble; responses 2 cycles apart.
- Reset mid-burst: assert rst during the WAIT of beat 3 of a write burst of 0xB0..0xB7 at 0x0040 over old contents 0 → reads return 0xB0, 0xB1, 0xB2, then 0 at 0x0043..0x0047.
- Busy ignore: pulse req_valid with req_we = 1 to 0x0020 while a read burst is busy → no write to 0x0020; the burst completes unchanged.
